accum_unit: RTL and testbench

Parametrised hardware accumulator driven by the board push-buttons and slide switches. It moves the switch-accumulate function out of Nios II software and into FPGA fabric. It synchronises and debounces the raw active-low buttons, and applies one arithmetic operation per debounced press to a wide accumulator register. It sits in the top level beside the SoC and drives the LED bank directly; the SoC may read its outputs through a PIO.

---
 rtl/accum_pkg.sv | 20 ++
 rtl/debounce.sv | 57 +++++
 rtl/accum_unit.sv | 142 ++++++++++++++
 tb/tb_accum_unit.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types for the push-button accumulator.
package accum_pkg;

  // Width of the Mode encoding
  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ModeAdd  = 2'b00,
    ModeSub  = 2'b01,
    ModeLoad = 2'b10,
    ModeXor  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StApply = 2'b01,
    StHold  = 2'b10
  } state_t;

endpackage

// File: rtl/debounce.sv
// Synchronises a raw active-low button and accepts a level change only after it
// has been stable for DEBOUNCE_CYC consecutive cycles. Output is the accepted
// active-low level.
module debounce #(
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_n_i,
  output logic level_n_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  // Two-flop synchroniser; resets to the released (high) level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= raw_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Count cycles of disagreement; flip the accepted level once the count saturates
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Counter and accepted-level registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_n_o = level_q;

endmodule

// File: rtl/accum_unit.sv
// Button-driven accumulator: one arithmetic operation per debounced Run press,
// level-acting Clear, sticky carry/borrow flag and a press counter.
module accum_unit
  import accum_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ACC_W        = 8,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned SATURATE     = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run_n,
  input  logic              Clear_n,
  input  logic [DATA_W-1:0] SW,
  input  logic [MODE_W-1:0] Mode,
  output logic [ACC_W-1:0]  Acc,
  output logic              Overflow,
  output logic [7:0]        Press_Count,
  output logic              Busy
);

  logic              run_level_n, clear_level_n;
  logic              run_pressed, clear_pressed;
  logic [DATA_W-1:0] sw_sync1_q, sw_sync2_q;
  logic [ACC_W-1:0]  op;
  logic [ACC_W:0]    sum, diff;
  mode_t             mode;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        press_cnt_q, press_cnt_d;
  logic              busy_q, busy_d;

  debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_run_db (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .raw_n_i  (Run_n),
    .level_n_o(run_level_n)
  );

  debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_clear_db (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .raw_n_i  (Clear_n),
    .level_n_o(clear_level_n)
  );

  assign run_pressed   = ~run_level_n;
  assign clear_pressed = ~clear_level_n;

  // Switch operand synchroniser; the switches are quasi-static so per-bit sync is enough
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= SW;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  // Mode is used unsynchronised; it must be static around a press
  assign mode = mode_t'(Mode);
  assign op   = ACC_W'(sw_sync2_q);
  // Extra top bit carries out of ADD and borrows out of SUB
  assign sum  = {1'b0, acc_q} + {1'b0, op};
  assign diff = {1'b0, acc_q} - {1'b0, op};

  // FSM next state: one operation per accepted press, rearm on release
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (run_pressed) state_d = StApply;
      StApply: state_d = StHold;
      StHold:  if (!run_pressed) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Datapath next state; Clear overrides the operation but not the press count
  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    press_cnt_d = press_cnt_q;
    if (state_q == StApply) begin
      press_cnt_d = press_cnt_q + 8'd1;
      unique case (mode)
        ModeAdd: begin
          acc_d = sum[ACC_W-1:0];
          if (sum[ACC_W]) begin
            ovf_d = 1'b1;
            if (SATURATE != 0) acc_d = '1;
          end
        end
        ModeSub: begin
          acc_d = diff[ACC_W-1:0];
          if (diff[ACC_W]) begin
            ovf_d = 1'b1;
            if (SATURATE != 0) acc_d = '0;
          end
        end
        ModeLoad: acc_d = op;
        ModeXor:  acc_d = acc_q ^ op;
        default:  acc_d = acc_q;
      endcase
    end
    if (clear_pressed) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      press_cnt_q <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      press_cnt_q <= press_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign Acc         = acc_q;
  assign Overflow    = ovf_q;
  assign Press_Count = press_cnt_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_accum_unit.sv
// Self-checking bench for accum_unit: wrapping and saturating instances share stimulus.
module tb_accum_unit;

  localparam int unsigned DC = 4;

  logic       clk = 1'b0;
  logic       rst, run_n, clear_n;
  logic [7:0] sw;
  logic [1:0] mode;

  logic [7:0] acc_w, acc_s, cnt_w, cnt_s;
  logic       ovf_w, ovf_s, busy_w, busy_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] acc_w;
    logic [7:0] acc_s;
    logic       ovf_w;
    logic       ovf_s;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state: index 0 wraps, index 1 saturates
  int m_acc[2];
  bit m_ovf[2];
  int m_cnt;

  accum_unit #(.DATA_W(8), .ACC_W(8), .DEBOUNCE_CYC(DC), .SATURATE(0)) dut_wrap (
    .Clk(clk), .Reset(rst), .Run_n(run_n), .Clear_n(clear_n), .SW(sw), .Mode(mode),
    .Acc(acc_w), .Overflow(ovf_w), .Press_Count(cnt_w), .Busy(busy_w)
  );

  accum_unit #(.DATA_W(8), .ACC_W(8), .DEBOUNCE_CYC(DC), .SATURATE(1)) dut_sat (
    .Clk(clk), .Reset(rst), .Run_n(run_n), .Clear_n(clear_n), .SW(sw), .Mode(mode),
    .Acc(acc_s), .Overflow(ovf_s), .Press_Count(cnt_s), .Busy(busy_s)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_apply(input int md, input int v);
    int s;
    for (int i = 0; i < 2; i++) begin
      case (md)
        0: begin
          s = m_acc[i] + v;
          if (s > 255) begin
            m_ovf[i] = 1'b1;
            s = (i == 1) ? 255 : s - 256;
          end
          m_acc[i] = s;
        end
        1: begin
          s = m_acc[i] - v;
          if (s < 0) begin
            m_ovf[i] = 1'b1;
            s = (i == 1) ? 0 : s + 256;
          end
          m_acc[i] = s;
        end
        2: m_acc[i] = v;
        default: m_acc[i] = m_acc[i] ^ v;
      endcase
    end
    m_cnt = (m_cnt + 1) % 256;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endfunction

  function automatic void push_expected();
    exp_t e;
    e.acc_w = 8'(m_acc[0]);
    e.acc_s = 8'(m_acc[1]);
    e.ovf_w = m_ovf[0];
    e.ovf_s = m_ovf[1];
    e.cnt   = 8'(m_cnt);
    sb.push_back(e);
  endfunction

  // Scoreboard monitor: every Press_Count step pops one expected result
  logic [7:0] prev_cnt = 8'd0;
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      prev_cnt = 8'd0;
    end else if (cnt_w !== prev_cnt) begin
      prev_cnt = cnt_w;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_update cnt got %h want no update", cnt_w);
      end else begin
        e = sb.pop_front();
        checks++;
        if (acc_w !== e.acc_w) begin
          errors++;
          $display("FAIL sb_acc_wrap got %h want %h", acc_w, e.acc_w);
        end
        checks++;
        if (acc_s !== e.acc_s) begin
          errors++;
          $display("FAIL sb_acc_sat got %h want %h", acc_s, e.acc_s);
        end
        checks++;
        if (ovf_w !== e.ovf_w || ovf_s !== e.ovf_s) begin
          errors++;
          $display("FAIL sb_ovf got %b/%b want %b/%b", ovf_w, ovf_s, e.ovf_w, e.ovf_s);
        end
        checks++;
        if (cnt_w !== e.cnt || cnt_s !== e.cnt) begin
          errors++;
          $display("FAIL sb_cnt got %h/%h want %h", cnt_w, cnt_s, e.cnt);
        end
      end
    end
  end

  // One full press/release with bounded waits; results checked by the monitor
  task automatic press(input logic [1:0] md, input logic [7:0] v, input int hold);
    int n;
    mode = md;
    sw   = v;
    model_apply(int'(md), int'(v));
    push_expected();
    run_n = 1'b0;
    n = 0;
    while (busy_w !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_w !== 1'b1) begin
      errors++;
      $display("FAIL press_busy got %b want 1", busy_w);
    end
    repeat (hold) @(negedge clk);
    run_n = 1'b1;
    n = 0;
    while (busy_w !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_w !== 1'b0) begin
      errors++;
      $display("FAIL release_idle busy got %b want 0", busy_w);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_clear();
    clear_n = 1'b0;
    repeat (DC + 4) @(negedge clk);
    clear_n = 1'b1;
    repeat (DC + 4) @(negedge clk);
    model_clear();
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    run_n   = 1'b1;
    clear_n = 1'b1;
    sw      = 8'h00;
    mode    = 2'b00;
    model_reset();
    #12 rst = 1'b1;
    #1;
    checks++;
    if (acc_w !== 8'h00 || acc_s !== 8'h00) begin
      errors++;
      $display("FAIL reset_acc got %h/%h want 00", acc_w, acc_s);
    end
    checks++;
    if (ovf_w !== 1'b0 || busy_w !== 1'b0 || ovf_s !== 1'b0 || busy_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags ovf %b busy %b want 0 0", ovf_w, busy_w);
    end
    checks++;
    if (cnt_w !== 8'h00 || cnt_s !== 8'h00) begin
      errors++;
      $display("FAIL reset_cnt got %h/%h want 00", cnt_w, cnt_s);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_add_timing();
    mode = 2'b00;
    sw   = 8'h05;
    repeat (3) @(negedge clk);
    model_apply(0, 5);
    push_expected();
    run_n = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy_w !== 1'b0 || acc_w !== 8'h00) begin
      errors++;
      $display("FAIL add_edge5 busy %b acc %h want 0 00", busy_w, acc_w);
    end
    @(negedge clk);
    checks++;
    if (busy_w !== 1'b1 || acc_w !== 8'h00) begin
      errors++;
      $display("FAIL add_edge6 busy %b acc %h want 1 00", busy_w, acc_w);
    end
    @(negedge clk);
    checks++;
    if (acc_w !== 8'h05 || cnt_w !== 8'h01) begin
      errors++;
      $display("FAIL add_edge7 acc %h cnt %h want 05 01", acc_w, cnt_w);
    end
    repeat (43) @(negedge clk);
    checks++;
    if (acc_w !== 8'h05 || cnt_w !== 8'h01 || busy_w !== 1'b1) begin
      errors++;
      $display("FAIL add_held acc %h cnt %h busy %b want 05 01 1", acc_w, cnt_w, busy_w);
    end
    run_n = 1'b1;
    repeat (DC + 4) @(negedge clk);
    checks++;
    if (busy_w !== 1'b0) begin
      errors++;
      $display("FAIL add_release busy got %b want 0", busy_w);
    end
    press(2'b00, 8'h05, 5);
    checks++;
    if (acc_w !== 8'h0A || cnt_w !== 8'h02) begin
      errors++;
      $display("FAIL add_second acc %h cnt %h want 0a 02", acc_w, cnt_w);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] a0, c0;
    logic       pat [7];
    bit         saw_busy;
    pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    a0 = acc_w;
    c0 = cnt_w;
    saw_busy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run_n = pat[i];
      @(negedge clk);
      if (busy_w !== 1'b0) saw_busy = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy_w !== 1'b0) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy) begin
      errors++;
      $display("FAIL bounce_busy got 1 want 0");
    end
    checks++;
    if (acc_w !== a0 || cnt_w !== c0) begin
      errors++;
      $display("FAIL bounce_state acc %h cnt %h want %h %h", acc_w, cnt_w, a0, c0);
    end
  endtask

  task automatic test_overflow();
    press(2'b10, 8'hFE, 3);
    press(2'b00, 8'h03, 3);
    checks++;
    if (acc_w !== 8'h01 || ovf_w !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap acc %h ovf %b want 01 1", acc_w, ovf_w);
    end
    checks++;
    if (acc_s !== 8'hFF || ovf_s !== 1'b1) begin
      errors++;
      $display("FAIL add_sat acc %h ovf %b want ff 1", acc_s, ovf_s);
    end
    press(2'b10, 8'h10, 3);
    checks++;
    if (acc_w !== 8'h10 || acc_s !== 8'h10 || ovf_w !== 1'b1 || ovf_s !== 1'b1) begin
      errors++;
      $display("FAIL load_sticky acc %h/%h ovf %b/%b want 10 1", acc_w, acc_s, ovf_w, ovf_s);
    end
    press(2'b11, 8'h3C, 3);
  endtask

  task automatic test_sub_clear();
    logic [7:0] c0;
    do_clear();
    press(2'b10, 8'h02, 3);
    press(2'b01, 8'h05, 3);
    checks++;
    if (acc_w !== 8'hFD || ovf_w !== 1'b1 || acc_s !== 8'h00 || ovf_s !== 1'b1) begin
      errors++;
      $display("FAIL sub_borrow acc %h/%h ovf %b/%b want fd/00 1", acc_w, acc_s, ovf_w, ovf_s);
    end
    c0 = cnt_w;
    clear_n = 1'b0;
    repeat (DC + 2) @(negedge clk);
    checks++;
    if (acc_w !== 8'hFD) begin
      errors++;
      $display("FAIL clear_early acc got %h want fd", acc_w);
    end
    @(negedge clk);
    checks++;
    if (acc_w !== 8'h00 || ovf_w !== 1'b0 || acc_s !== 8'h00 || ovf_s !== 1'b0) begin
      errors++;
      $display("FAIL clear_apply acc %h ovf %b want 00 0", acc_w, ovf_w);
    end
    clear_n = 1'b1;
    repeat (DC + 4) @(negedge clk);
    model_clear();
    checks++;
    if (cnt_w !== c0 || busy_w !== 1'b0) begin
      errors++;
      $display("FAIL clear_cnt cnt %h busy %b want %h 0", cnt_w, busy_w, c0);
    end
  endtask

  task automatic test_run_clear();
    press(2'b10, 8'h33, 3);
    mode = 2'b00;
    sw   = 8'h07;
    repeat (3) @(negedge clk);
    model_apply(0, 7);
    model_clear();
    push_expected();
    run_n   = 1'b0;
    clear_n = 1'b0;
    repeat (DC + 9) @(negedge clk);
    checks++;
    if (acc_w !== 8'h00 || acc_s !== 8'h00 || cnt_w !== 8'(m_cnt) || busy_w !== 1'b1) begin
      errors++;
      $display("FAIL run_clear acc %h cnt %h busy %b want 00 %h 1", acc_w, cnt_w, busy_w,
               8'(m_cnt));
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL run_clear_pending got %0d want 0", sb.size());
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy_w !== 1'b0 || acc_w !== 8'h00 || cnt_w !== 8'h00 || ovf_w !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold busy %b acc %h cnt %h want 0 00 00", busy_w, acc_w, cnt_w);
    end
    @(negedge clk);
    run_n   = 1'b1;
    clear_n = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    press(2'b00, 8'h07, 15);
    checks++;
    if (acc_w !== 8'h07 || cnt_w !== 8'h01 || acc_s !== 8'h07) begin
      errors++;
      $display("FAIL post_reset acc %h cnt %h want 07 01", acc_w, cnt_w);
    end
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_bounce();
    test_overflow();
    test_sub_clear();
    test_run_clear();
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
